bcd_serial_adder: RTL and testbench

Parametrised, digit-serial BCD adder for multi-digit packed-BCD operands. It processes one 4-bit BCD digit per clock, least-significant digit first, and uses a start/busy/done handshake. It trades latency for area compared with a combinational multi-digit adder. It sits between the operand registers and the BCD display/result path of the calculator datapath.

---
 rtl/bcd_serial_adder_if.sv | 59 +++++
 rtl/bcd_serial_adder.sv | 155 +++++++++++++++
 tb/tb_bcd_serial_adder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// ----------------------------------------------------------------------------
// bcd_serial_adder_if
//
// Purpose:
//   Bundles the start/busy/done handshake, the packed-BCD operands and the
//   result of bcd_serial_adder into one interface. The requester uses the
//   master modport and the adder uses the slave modport.
//
// Parameters:
//   DIGITS - number of BCD digits per operand; bus width is 4*DIGITS.
//
// Signals:
//   start  master->slave  request, only honoured while busy=0
//   a, b   master->slave  packed-BCD operands, digit 0 in bits [3:0]
//   cin    master->slave  decimal carry-in to digit 0
//   sub    master->slave  subtract mode (only when BCD_SUB_EN is defined)
//   busy   slave->master  high while digits are being processed
//   done   slave->master  one-cycle pulse when the result is valid
//   s      slave->master  packed-BCD result, held until the next start
//   cout   slave->master  decimal carry out of the top digit
//   err    slave->master  sticky: a latched operand digit was above 9
//
// Configuration:
//   BCD_SUB_EN - when defined, adds the sub signal to both modports.
// ----------------------------------------------------------------------------
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
`ifdef BCD_SUB_EN
    logic                  sub;
`endif
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   s;
    logic                  cout;
    logic                  err;

    // The requester drives the operands and start, and watches the result.
    modport master (
        output start, a, b, cin,
`ifdef BCD_SUB_EN
        output sub,
`endif
        input  busy, done, s, cout, err
    );

    // The adder consumes the operands and drives the result.
    modport slave (
        input  start, a, b, cin,
`ifdef BCD_SUB_EN
        input  sub,
`endif
        output busy, done, s, cout, err
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// ----------------------------------------------------------------------------
// bcd_serial_adder
//
// Purpose:
//   Digit-serial packed-BCD adder. After an accepted start it processes one
//   BCD digit per clock, least-significant digit first, and pulses done
//   DIGITS cycles after the start edge. The result, carry-out and error flag
//   are held until the next accepted start.
//
// Parameters:
//   DIGITS - number of BCD digits per operand (>= 1).
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - bcd_serial_adder_if slave modport (start/a/b/cin[/sub] in,
//          busy/done/s/cout/err out)
//
// Configuration:
//   BCD_SUB_EN - when defined, sub=1 at start turns the operation into a-b
//                using nines complement of b and a forced carry-in of 1.
//                When undefined, the block only adds.
// ----------------------------------------------------------------------------
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_serial_adder_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IW-1:0]    r_digitIdx;
    logic [W-1:0]     r_s;
    logic             r_cout;
    logic             r_err;
    logic             r_busy;
    logic             r_done;

    logic [W-1:0]     w_bLatch;
    logic             w_cinLatch;
    logic             w_opErr;
    logic [3:0]       w_aDigit;
    logic [3:0]       w_bDigit;
    logic [4:0]       w_digitSum;
    logic             w_overNine;
    logic [3:0]       w_sumDigit;
    logic             w_lastDigit;

    // Work out what gets captured when a start is accepted. The error flag
    // always looks at the raw operand digits. In subtract mode b is stored as
    // its nines complement and the carry-in is forced to 1, so that the
    // serial add below produces a + (10^DIGITS - 1 - b) + 1.
    always_comb begin
        w_opErr    = 1'b0;
        w_bLatch   = bus.b;
        w_cinLatch = bus.cin;
        for (int k = 0; k < DIGITS; k++) begin
            if ((bus.a[4*k +: 4] > 4'd9) || (bus.b[4*k +: 4] > 4'd9)) begin
                w_opErr = 1'b1;
            end
        end
`ifdef BCD_SUB_EN
        if (bus.sub) begin
            w_cinLatch = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                w_bLatch[4*k +: 4] = 4'd9 - bus.b[4*k +: 4];
            end
        end
`endif
    end

    // One decimal digit step. The digit is picked by shifting the latched
    // operands down by four times the digit index. A binary sum above 9 is
    // corrected by adding 6 and keeping the low nibble, which also produces
    // the decimal carry into the next digit.
    always_comb begin
        w_aDigit    = 4'(r_a >> {r_digitIdx, 2'b00});
        w_bDigit    = 4'(r_b >> {r_digitIdx, 2'b00});
        w_digitSum  = 5'(w_aDigit) + 5'(w_bDigit) + 5'(r_carry);
        w_overNine  = (w_digitSum > 5'd9);
        w_sumDigit  = w_overNine ? (w_digitSum[3:0] + 4'd6) : w_digitSum[3:0];
        w_lastDigit = (r_digitIdx == IW'(DIGITS - 1));
    end

    // Control FSM and datapath registers. IDLE waits for start and captures
    // the operands. RUN writes one result digit per edge and finishes on the
    // top digit. The result register is cleared at start, so each digit is
    // ORed into its slot. done defaults low so that it only lasts one cycle,
    // and reset wins over everything, including a start in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_digitIdx <= '0;
            r_s        <= '0;
            r_cout     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a        <= bus.a;
                        r_b        <= w_bLatch;
                        r_carry    <= w_cinLatch;
                        r_digitIdx <= '0;
                        r_s        <= '0;
                        r_cout     <= 1'b0;
                        r_err      <= w_opErr;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_s     <= r_s | (W'(w_sumDigit) << {r_digitIdx, 2'b00});
                    r_carry <= w_overNine;
                    if (w_lastDigit) begin
                        r_cout  <= w_overNine;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_digitIdx <= r_digitIdx + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_bcd_serial_adder
//
// Purpose:
//   Self-checking bench for bcd_serial_adder with DIGITS=4. Directed cases
//   cover plain add, ripple carry, invalid digits, start while busy, start
//   held high, reset mid-operation and reset-over-start; a randomized loop
//   follows. Expected results come from a decimal reference model.
//
// Configuration:
//   BCD_SUB_EN - when defined, subtract cases are also driven.
// ----------------------------------------------------------------------------
module tb_bcd_serial_adder;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst;

    int checkCount = 0;
    int failCount  = 0;

    bcd_serial_adder_if #(.DIGITS(DIGITS)) busIf ();

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model. Valid operands are handled as plain decimal integers;
    // operands with a digit above 9 fall back to the digit-by-digit rule.
    task automatic refModel(input logic [W-1:0] a, b, input logic cin, sub,
                            output logic [W-1:0] s, output logic cout,
                            output logic err);
        int limit = 1;
        int total;
        int c;
        int t;
        logic [W-1:0] bEff;
        for (int k = 0; k < DIGITS; k++) limit = limit * 10;
        err = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) err = 1'b1;
        end
        if (!err) begin
            if (sub) begin
                if (bcdToInt(a) >= bcdToInt(b)) begin
                    s = intToBcd(bcdToInt(a) - bcdToInt(b));
                    cout = 1'b1;
                end else begin
                    s = intToBcd(limit - (bcdToInt(b) - bcdToInt(a)));
                    cout = 1'b0;
                end
            end else begin
                total = bcdToInt(a) + bcdToInt(b) + int'(cin);
                s     = intToBcd(total % limit);
                cout  = (total >= limit);
            end
        end else begin
            bEff = b;
            c    = int'(cin);
            if (sub) begin
                c = 1;
                for (int k = 0; k < DIGITS; k++) bEff[4*k +: 4] = 4'd9 - b[4*k +: 4];
            end
            s = '0;
            for (int k = 0; k < DIGITS; k++) begin
                t = int'(a[4*k +: 4]) + int'(bEff[4*k +: 4]) + c;
                if (t > 9) begin
                    s[4*k +: 4] = 4'(t + 6);
                    c = 1;
                end else begin
                    s[4*k +: 4] = 4'(t);
                    c = 0;
                end
            end
            cout = c[0];
        end
    endtask

    // Runs one operation and checks the handshake on every edge. pokeStart
    // pulses start with different operands mid-run; holdStart leaves start
    // high so the next call's start lands in the done cycle.
    task automatic applyStimulus(input logic [W-1:0] a, b, input logic cin, sub,
                                 input bit pokeStart, holdStart, input string name);
        logic [W-1:0] expS;
        logic expCout;
        logic expErr;
        refModel(a, b, cin, sub, expS, expCout, expErr);
        busIf.a   = a;
        busIf.b   = b;
        busIf.cin = cin;
`ifdef BCD_SUB_EN
        busIf.sub = sub;
`endif
        busIf.start = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) busIf.start = 1'b0;
        checkOutput({name, ".busyAtStart"}, 32'(busIf.busy), 32'd1);
        checkOutput({name, ".doneAtStart"}, 32'(busIf.done), 32'd0);
        checkOutput({name, ".sCleared"},    32'(busIf.s),    32'd0);
        checkOutput({name, ".errLatched"},  32'(busIf.err),  32'(expErr));
        for (int k = 1; k <= DIGITS; k++) begin
            if (pokeStart && k == 1) begin
                busIf.start = 1'b1;
                busIf.a     = W'($urandom);
                busIf.b     = W'($urandom);
            end
            if (pokeStart && k == 2) busIf.start = 1'b0;
            @(posedge clk); #1;
            if (k < DIGITS) begin
                checkOutput($sformatf("%s.busyEdge%0d", name, k), 32'(busIf.busy), 32'd1);
                checkOutput($sformatf("%s.doneEdge%0d", name, k), 32'(busIf.done), 32'd0);
            end else begin
                checkOutput({name, ".done"}, 32'(busIf.done), 32'd1);
                checkOutput({name, ".busy"}, 32'(busIf.busy), 32'd0);
                checkOutput({name, ".s"},    32'(busIf.s),    32'(expS));
                checkOutput({name, ".cout"}, 32'(busIf.cout), 32'(expCout));
                checkOutput({name, ".err"},  32'(busIf.err),  32'(expErr));
            end
        end
        if (!holdStart) begin
            @(posedge clk); #1;
            checkOutput({name, ".doneDrop"}, 32'(busIf.done), 32'd0);
            checkOutput({name, ".idle"},     32'(busIf.busy), 32'd0);
            checkOutput({name, ".sHeld"},    32'(busIf.s),    32'(expS));
            checkOutput({name, ".coutHeld"}, 32'(busIf.cout), 32'(expCout));
        end
    endtask

    function automatic logic [W-1:0] randomOperand();
        logic [W-1:0] v;
        for (int k = 0; k < DIGITS; k++) begin
            if ($urandom_range(0, 7) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
            else                           v[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Main sequence: reset checks, directed scenarios, then random operations.
    initial begin
        rst         = 1'b1;
        busIf.start = 1'b0;
        busIf.a     = '0;
        busIf.b     = '0;
        busIf.cin   = 1'b0;
`ifdef BCD_SUB_EN
        busIf.sub   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy", 32'(busIf.busy), 32'd0);
        checkOutput("reset.done", 32'(busIf.done), 32'd0);
        checkOutput("reset.s",    32'(busIf.s),    32'd0);
        checkOutput("reset.cout", 32'(busIf.cout), 32'd0);
        checkOutput("reset.err",  32'(busIf.err),  32'd0);

        busIf.a     = 16'h00A0;
        busIf.start = 1'b1;
        @(posedge clk); #1;
        checkOutput("resetOverStart.busy", 32'(busIf.busy), 32'd0);
        checkOutput("resetOverStart.err",  32'(busIf.err),  32'd0);
        busIf.start = 1'b0;
        rst         = 1'b0;
        @(posedge clk); #1;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, "basic");
        applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, "ripple");
        applyStimulus(16'h0999, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, "rippleCin");
        applyStimulus(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "invalid");
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, "errClear");
        applyStimulus(16'h2468, 16'h1357, 1'b0, 1'b0, 1'b1, 1'b0, "startWhileBusy");
        applyStimulus(16'h5000, 16'h5000, 1'b0, 1'b0, 1'b0, 1'b1, "held1");
        applyStimulus(16'h0123, 16'h0877, 1'b1, 1'b0, 1'b0, 1'b1, "held2");
        applyStimulus(16'h8765, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, "held3");

        busIf.a     = 16'h1111;
        busIf.b     = 16'h2222;
        busIf.cin   = 1'b0;
        busIf.start = 1'b1;
        @(posedge clk); #1;
        busIf.start = 1'b0;
        @(posedge clk); #1;
        checkOutput("midReset.digit0", 32'(busIf.s), 32'h0003);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midReset.busy", 32'(busIf.busy), 32'd0);
        checkOutput("midReset.s",    32'(busIf.s),    32'd0);
        checkOutput("midReset.cout", 32'(busIf.cout), 32'd0);
        for (int k = 0; k < DIGITS + 2; k++) begin
            checkOutput($sformatf("midReset.noDone%0d", k), 32'(busIf.done), 32'd0);
            @(posedge clk); #1;
        end

`ifdef BCD_SUB_EN
        applyStimulus(16'h0500, 16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, "subPos");
        applyStimulus(16'h0123, 16'h0500, 1'b1, 1'b1, 1'b0, 1'b0, "subNeg");
`endif

        for (int n = 0; n < 40; n++) begin
            logic subBit = 1'b0;
`ifdef BCD_SUB_EN
            subBit = 1'($urandom_range(0, 1));
`endif
            applyStimulus(randomOperand(), randomOperand(), 1'($urandom_range(0, 1)),
                          subBit, 1'b0, 1'b0, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
